irq_ctrl: RTL and testbench

- Parametrised multi-source interrupt controller that drives the core's single `intrrupt` input.
- Replaces the single hand-driven interrupt pulse with NUM_SRC synchronised sources (UART RX/TX, timer, external).
- Per-source enable and edge/level mode, fixed priority, and a claim/complete handshake with the core's trap handler.
- Selectable pulse or level output to the core.

---
 rtl/irq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl - multi-source interrupt controller feeding the core's single
// interrupt input.
//
// Each raw source is synchronised, then latched into a pending bit either on
// a rising edge or while high (per-source mode). Among enabled pending
// sources the lowest index wins. A single request is presented to the core
// at a time, and the core acknowledges it with a claim/complete handshake.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   src_irq      raw asynchronous interrupt requests, one per source
//   cfg_en       per-source enable (masks arbitration only, not latching)
//   cfg_edge     per-source mode: 1 = rising edge, 0 = level-high
//   claim        core acknowledges the presented request (1-cycle strobe)
//   complete     handler finished (1-cycle strobe)
//   complete_id  ID of the source being completed
//   intrrupt     request to core (pulse or level, see PULSE_OUT)
//   irq_id       ID (index+1) of presented / in-service source, 0 when idle
//   pending      raw pending bits, before enable masking
// ---------------------------------------------------------------------------
module irq_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int ID_W        = $clog2(NUM_SRC + 1),
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_OUT   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic [NUM_SRC-1:0] cfg_en,
    input  logic [NUM_SRC-1:0] cfg_edge,
    input  logic               claim,
    input  logic               complete,
    input  logic [ID_W-1:0]    complete_id,
    output logic               intrrupt,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync_d [SYNC_STAGES];
    logic [NUM_SRC-1:0] s_prev_q, s_prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               int_q, int_d;

    logic [NUM_SRC-1:0] s;        // synchronised sources
    logic [NUM_SRC-1:0] rise;     // rising edge of synchronised sources
    logic [NUM_SRC-1:0] sel;      // one-hot of the source named by id_q
    logic [NUM_SRC-1:0] req;      // arbitration candidates
    logic [NUM_SRC-1:0] held;     // source claimed now or in service
    logic [ID_W-1:0]    win_id;
    logic               claim_ok;
    logic               drop;

    // Synchroniser chain: stage 0 samples the raw inputs.
    always_comb begin
        sync_d[0] = src_irq;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign s_prev_d = s;
    assign rise     = s & ~s_prev_q;
    assign req      = pending_q & cfg_en;
    assign claim_ok = (state_q == PRESENT) && claim;
    assign held     = sel & {NUM_SRC{claim_ok || (state_q == SERVICE)}};

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign sel[gi] = (id_q == ID_W'(gi + 1));

            // Edge: a new edge beats a same-cycle claim clear and can re-pend
            // the in-service source (one deep). Level: follows the input, but
            // the claimed / in-service source is gated until completion.
            always_comb begin
                if (cfg_edge[gi]) begin
                    pending_d[gi] = rise[gi] | (pending_q[gi] & ~(sel[gi] & claim_ok));
                end else begin
                    pending_d[gi] = s[gi] & ~held[gi];
                end
            end
        end
    endgenerate

    // Fixed priority: lowest index wins.
    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_id = ID_W'(i + 1);
            end
        end
    end

    // Presented source was disabled, or its level request went away.
    assign drop = |(sel & ~cfg_en) || |(sel & ~cfg_edge & ~pending_q);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        int_d   = 1'b0;
        case (state_q)
            IDLE: begin
                id_d = '0;
                if (|req) begin
                    state_d = PRESENT;
                    id_d    = win_id;
                    int_d   = 1'b1;
                end
            end
            PRESENT: begin
                if (claim) begin
                    state_d = SERVICE;
                end else if (drop) begin
                    state_d = IDLE;
                    id_d    = '0;
                end else begin
                    int_d = (PULSE_OUT == 0);
                end
            end
            SERVICE: begin
                if (complete && (complete_id == id_q)) begin
                    state_d = IDLE;
                    id_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                id_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            s_prev_q  <= '0;
            pending_q <= '0;
            state_q   <= IDLE;
            id_q      <= '0;
            int_q     <= 1'b0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            s_prev_q  <= s_prev_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            id_q      <= id_d;
            int_q     <= int_d;
        end
    end

    assign intrrupt = int_q;
    assign irq_id   = id_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 4 sources, pulse output
    logic       rst_a;
    logic [3:0] src_a, en_a, edg_a, pend_a;
    logic       claim_a, comp_a, int_a;
    logic [2:0] cid_a, id_a;

    // DUT B: 8 sources, level output
    logic       rst_b;
    logic [7:0] src_b, en_b, edg_b, pend_b;
    logic       claim_b, comp_b, int_b;
    logic [3:0] cid_b, id_b;

    irq_ctrl #(.NUM_SRC(4), .ID_W(3), .SYNC_STAGES(2), .PULSE_OUT(1)) u_a (
        .clk(clk), .reset(rst_a), .src_irq(src_a), .cfg_en(en_a), .cfg_edge(edg_a),
        .claim(claim_a), .complete(comp_a), .complete_id(cid_a),
        .intrrupt(int_a), .irq_id(id_a), .pending(pend_a)
    );

    irq_ctrl #(.NUM_SRC(8), .ID_W(4), .SYNC_STAGES(2), .PULSE_OUT(0)) u_b (
        .clk(clk), .reset(rst_b), .src_irq(src_b), .cfg_en(en_b), .cfg_edge(edg_b),
        .claim(claim_b), .complete(comp_b), .complete_id(cid_b),
        .intrrupt(int_b), .irq_id(id_b), .pending(pend_b)
    );

    typedef struct {
        string      name;
        logic [7:0] src;
        logic [7:0] en;
        logic [7:0] edg;
        logic       clm;
        logic       cmp;
        logic [3:0] cid;
        logic       e_int;
        logic [3:0] e_id;
        logic [7:0] e_pend;
    } vec_t;

    typedef struct {
        string      name;
        int         dut;
        logic       e_int;
        logic [3:0] e_id;
        logic [7:0] e_pend;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input string fld, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", name, fld, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [7:0] src, input logic [7:0] en,
                                input logic [7:0] edg, input logic clm, input logic cmp,
                                input logic [3:0] cid, input logic ei, input logic [3:0] eid,
                                input logic [7:0] ep);
        vec_t v;
        v.name = n; v.src = src; v.en = en; v.edg = edg; v.clm = clm; v.cmp = cmp;
        v.cid = cid; v.e_int = ei; v.e_id = eid; v.e_pend = ep;
        return v;
    endfunction

    task automatic add(input string n, input logic [7:0] src, input logic [7:0] en,
                       input logic [7:0] edg, input logic clm, input logic cmp,
                       input logic [3:0] cid, input logic ei, input logic [3:0] eid,
                       input logic [7:0] ep);
        tbl.push_back(mk(n, src, en, edg, clm, cmp, cid, ei, eid, ep));
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input int dut, input vec_t v);
        exp_t e;
        exp_t got;
        if (dut == 0) begin
            src_a = v.src[3:0]; en_a = v.en[3:0]; edg_a = v.edg[3:0];
            claim_a = v.clm; comp_a = v.cmp; cid_a = v.cid[2:0];
        end else begin
            src_b = v.src; en_b = v.en; edg_b = v.edg;
            claim_b = v.clm; comp_b = v.cmp; cid_b = v.cid;
        end
        e.name = v.name; e.dut = dut; e.e_int = v.e_int; e.e_id = v.e_id; e.e_pend = v.e_pend;
        sb.push_back(e);
        @(posedge clk);
        #2;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            got = sb.pop_front();
            if (got.dut == 0) begin
                $display("tx %s A int=%0b id=%0d pend=%0h", got.name, int_a, id_a, pend_a);
                chk(got.name, "intrrupt", {7'd0, int_a}, {7'd0, got.e_int});
                chk(got.name, "irq_id", {5'd0, id_a}, {4'd0, got.e_id});
                chk(got.name, "pending", {4'd0, pend_a}, got.e_pend);
            end else begin
                $display("tx %s B int=%0b id=%0d pend=%0h", got.name, int_b, id_b, pend_b);
                chk(got.name, "intrrupt", {7'd0, int_b}, {7'd0, got.e_int});
                chk(got.name, "irq_id", {4'd0, id_b}, {4'd0, got.e_id});
                chk(got.name, "pending", pend_b, got.e_pend);
            end
        end
        src_a = '0; claim_a = 1'b0; comp_a = 1'b0; cid_a = '0;
        src_b = '0; claim_b = 1'b0; comp_b = 1'b0; cid_b = '0;
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        src_a = '0; en_a = 4'hF; edg_a = 4'hF; claim_a = 1'b0; comp_a = 1'b0; cid_a = '0;
        src_b = '0; en_b = 8'hFF; edg_b = 8'hFF; claim_b = 1'b0; comp_b = 1'b0; cid_b = '0;

        repeat (2) @(posedge clk);
        #2;
        chk("reset_a", "intrrupt", {7'd0, int_a}, 8'd0);
        chk("reset_a", "irq_id", {5'd0, id_a}, 8'd0);
        chk("reset_a", "pending", {4'd0, pend_a}, 8'd0);
        chk("reset_b", "intrrupt", {7'd0, int_b}, 8'd0);
        chk("reset_b", "irq_id", {4'd0, id_b}, 8'd0);
        chk("reset_b", "pending", pend_b, 8'd0);
        rst_a = 1'b1; rst_b = 1'b1;

        //   name      src  en   edg  clm cmp cid int id pend
        // single edge source: 3-cycle latch latency, 1-cycle pulse, handshake
        add("basic",   4, 'hF, 'hF, 0, 0, 0, 0, 0, 0);
        add("basic",   0, 'hF, 'hF, 0, 0, 0, 0, 0, 0);
        add("basic",   0, 'hF, 'hF, 0, 0, 0, 0, 0, 4);
        add("basic",   0, 'hF, 'hF, 0, 0, 0, 1, 3, 4);
        add("basic",   0, 'hF, 'hF, 0, 0, 0, 0, 3, 4);
        add("basic",   0, 'hF, 'hF, 1, 0, 0, 0, 3, 0);
        add("basic",   0, 'hF, 'hF, 0, 1, 3, 0, 0, 0);
        add("idleclm", 0, 'hF, 'hF, 1, 0, 0, 0, 0, 0);
        // simultaneous sources 0 and 3: lowest index first, IDLE gap, then 4
        add("prio",    9, 'hF, 'hF, 0, 0, 0, 0, 0, 0);
        add("prio",    0, 'hF, 'hF, 0, 0, 0, 0, 0, 0);
        add("prio",    0, 'hF, 'hF, 0, 0, 0, 0, 0, 9);
        add("prio",    0, 'hF, 'hF, 0, 0, 0, 1, 1, 9);
        add("prio",    0, 'hF, 'hF, 1, 0, 0, 0, 1, 8);
        add("prio",    0, 'hF, 'hF, 0, 1, 1, 0, 0, 8);
        add("prio",    0, 'hF, 'hF, 0, 0, 0, 1, 4, 8);
        add("prio",    0, 'hF, 'hF, 1, 0, 0, 0, 4, 0);
        add("prio",    0, 'hF, 'hF, 0, 1, 4, 0, 0, 0);
        // level source 1 drops before claim: presentation withdrawn
        add("level",   2, 'hF, 'hD, 0, 0, 0, 0, 0, 0);
        add("level",   2, 'hF, 'hD, 0, 0, 0, 0, 0, 0);
        add("level",   0, 'hF, 'hD, 0, 0, 0, 0, 0, 2);
        add("level",   0, 'hF, 'hD, 0, 0, 0, 1, 2, 2);
        add("level",   0, 'hF, 'hD, 0, 0, 0, 0, 2, 0);
        add("level",   0, 'hF, 'hD, 0, 0, 0, 0, 0, 0);
        // in service for 2: wrong complete ignored, re-edge re-pends
        add("svc",     2, 'hF, 'hF, 0, 0, 0, 0, 0, 0);
        add("svc",     0, 'hF, 'hF, 0, 0, 0, 0, 0, 0);
        add("svc",     0, 'hF, 'hF, 0, 0, 0, 0, 0, 2);
        add("svc",     0, 'hF, 'hF, 0, 0, 0, 1, 2, 2);
        add("svc",     0, 'hF, 'hF, 1, 0, 0, 0, 2, 0);
        add("svc",     2, 'hF, 'hF, 0, 1, 1, 0, 2, 0);
        add("svc",     0, 'hF, 'hF, 0, 0, 0, 0, 2, 0);
        add("svc",     0, 'hF, 'hF, 0, 0, 0, 0, 2, 2);
        add("svc",     0, 'hF, 'hF, 0, 0, 0, 0, 2, 2);
        add("svc",     0, 'hF, 'hF, 0, 1, 2, 0, 0, 2);
        add("svc",     0, 'hF, 'hF, 0, 0, 0, 1, 2, 2);
        add("svc",     0, 'hF, 'hF, 1, 0, 0, 0, 2, 0);
        add("svc",     0, 'hF, 'hF, 0, 1, 2, 0, 0, 0);
        // disabled source still latches pending, delivered once enabled
        add("dis",     1, 'hE, 'hF, 0, 0, 0, 0, 0, 0);
        add("dis",     0, 'hE, 'hF, 0, 0, 0, 0, 0, 0);
        add("dis",     0, 'hE, 'hF, 0, 0, 0, 0, 0, 1);
        add("dis",     0, 'hE, 'hF, 0, 0, 0, 0, 0, 1);
        add("dis",     0, 'hF, 'hF, 0, 0, 0, 1, 1, 1);
        add("dis",     0, 'hF, 'hF, 1, 0, 0, 0, 1, 0);
        add("dis",     0, 'hF, 'hF, 0, 1, 1, 0, 0, 0);
        // enable removed while presenting: back to IDLE, re-presented later
        add("unen",    1, 'hF, 'hF, 0, 0, 0, 0, 0, 0);
        add("unen",    0, 'hF, 'hF, 0, 0, 0, 0, 0, 0);
        add("unen",    0, 'hF, 'hF, 0, 0, 0, 0, 0, 1);
        add("unen",    0, 'hF, 'hF, 0, 0, 0, 1, 1, 1);
        add("unen",    0, 'hE, 'hF, 0, 0, 0, 0, 0, 1);
        add("unen",    0, 'hE, 'hF, 0, 0, 0, 0, 0, 1);
        add("unen",    0, 'hF, 'hF, 0, 0, 0, 1, 1, 1);
        add("unen",    0, 'hF, 'hF, 1, 0, 0, 0, 1, 0);
        add("unen",    0, 'hF, 'hF, 0, 1, 1, 0, 0, 0);

        for (int r = 0; r < tbl.size(); r++) begin
            step(0, tbl[r]);
        end

        // Hand sequence: second edge lands on the claim cycle, set wins.
        step(0, mk("race", 4, 'hF, 'hF, 0, 0, 0, 0, 0, 0));
        step(0, mk("race", 0, 'hF, 'hF, 0, 0, 0, 0, 0, 0));
        step(0, mk("race", 0, 'hF, 'hF, 0, 0, 0, 0, 0, 4));
        step(0, mk("race", 4, 'hF, 'hF, 0, 0, 0, 1, 3, 4));
        step(0, mk("race", 0, 'hF, 'hF, 0, 0, 0, 0, 3, 4));
        step(0, mk("race", 0, 'hF, 'hF, 1, 0, 0, 0, 3, 4));
        step(0, mk("race", 0, 'hF, 'hF, 0, 1, 3, 0, 0, 4));
        step(0, mk("race", 0, 'hF, 'hF, 0, 0, 0, 1, 3, 4));
        step(0, mk("race", 0, 'hF, 'hF, 1, 0, 0, 0, 3, 0));
        step(0, mk("race", 0, 'hF, 'hF, 0, 1, 3, 0, 0, 0));

        // Hand sequence on DUT B: level output held until claim.
        step(1, mk("lvlout", 'h80, 'hFF, 'hFF, 0, 0, 0, 0, 0, 'h00));
        step(1, mk("lvlout", 'h00, 'hFF, 'hFF, 0, 0, 0, 0, 0, 'h00));
        step(1, mk("lvlout", 'h00, 'hFF, 'hFF, 0, 0, 0, 0, 0, 'h80));
        step(1, mk("lvlout", 'h00, 'hFF, 'hFF, 0, 0, 0, 1, 8, 'h80));
        step(1, mk("lvlout", 'h00, 'hFF, 'hFF, 0, 0, 0, 1, 8, 'h80));
        step(1, mk("lvlout", 'h00, 'hFF, 'hFF, 0, 0, 0, 1, 8, 'h80));
        step(1, mk("lvlout", 'h00, 'hFF, 'hFF, 1, 0, 0, 0, 8, 'h00));
        step(1, mk("lvlout", 'h00, 'hFF, 'hFF, 0, 1, 8, 0, 0, 'h00));

        // Hand sequence on DUT B: asynchronous reset while presenting.
        step(1, mk("arst", 'h80, 'hFF, 'hFF, 0, 0, 0, 0, 0, 'h00));
        step(1, mk("arst", 'h00, 'hFF, 'hFF, 0, 0, 0, 0, 0, 'h00));
        step(1, mk("arst", 'h00, 'hFF, 'hFF, 0, 0, 0, 0, 0, 'h80));
        step(1, mk("arst", 'h00, 'hFF, 'hFF, 0, 0, 0, 1, 8, 'h80));
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        $display("tx arst_now B int=%0b id=%0d pend=%0h", int_b, id_b, pend_b);
        chk("arst_now", "intrrupt", {7'd0, int_b}, 8'd0);
        chk("arst_now", "irq_id", {4'd0, id_b}, 8'd0);
        chk("arst_now", "pending", pend_b, 8'd0);
        @(posedge clk);
        #2;
        rst_b = 1'b1;
        step(1, mk("arst_post", 'h00, 'hFF, 'hFF, 0, 0, 0, 0, 0, 'h00));
        step(1, mk("arst_post", 'h00, 'hFF, 'hFF, 0, 0, 0, 0, 0, 'h00));
        step(1, mk("arst_post", 'h00, 'hFF, 'hFF, 0, 0, 0, 0, 0, 'h00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
